token_tx_seq: RTL

- Transmit sequencer for the USB token path. Pops one pkt_t (PID, ADDR, ENDP) at a time from the 4-entry packet fifo.
- Serializes SYNC, PID, ADDR and ENDP into crc5's s_in, and frames the CRC window with start/endr.
- Honours the bit stuffer's pause.
- Idles through the 5 CRC bits that crc5 appends, then signals packet completion.

---
 rtl/usb_pkg.sv | 49 ++++
 rtl/token_tx_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/usb_pkg.sv
// Shared USB token-path types: PID encoding, packet record, SYNC pattern,
// field lengths and the transmit sequencer state encoding.
package usb_pkg;

    typedef enum logic [3:0] {
        OUT   = 4'b0001,
        IN    = 4'b1001,
        SOF   = 4'b0101,
        SETUP = 4'b1101
    } pid_t;

    typedef struct packed {
        pid_t       pid;
        logic [6:0] addr;
        logic [3:0] endp;
    } pkt_t;

    localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;

    localparam int SYNC_LEN = 8;
    localparam int PID_LEN  = 8;
    localparam int ADDR_LEN = 7;
    localparam int ENDP_LEN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_ADDR,
        ST_ENDP,
        ST_CRC,
        ST_GAP
    } tx_state_t;

    // Index of the final bit of a serialized field; 0 for non-field states.
    function automatic logic [2:0] field_last(input tx_state_t st);
        logic [2:0] last;
        last = 3'd0;
        case (st)
            ST_SYNC: last = 3'(SYNC_LEN - 1);
            ST_PID:  last = 3'(PID_LEN - 1);
            ST_ADDR: last = 3'(ADDR_LEN - 1);
            ST_ENDP: last = 3'(ENDP_LEN - 1);
            default: last = 3'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/token_tx_seq.sv
// USB token transmit sequencer: pops a packet, serializes SYNC/PID/ADDR/ENDP
// toward crc5, then idles through the CRC slots and an inter-packet gap.
module token_tx_seq
    import usb_pkg::*;
#(
    parameter int CRC_BITS = 5,
    parameter int GAP      = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fifo_empty,
    input  pkt_t pkt_in,
    output logic fifo_re,
    input  logic pause,
    input  logic abort,
    output logic bit_out,
    output logic bit_valid,
    output logic crc_start,
    output logic crc_endr,
    output logic busy,
    output logic pkt_done
);

    localparam logic [2:0] CRC_LAST = 3'(CRC_BITS - 1);
    localparam logic [2:0] GAP_LAST = 3'((GAP > 0) ? (GAP - 1) : 0);

    tx_state_t  state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    pkt_t       pkt_reg, pkt_next;
    logic [3:0] pid_bits;
    logic [7:0] pid_byte;
    logic       at_last;

    assign pid_bits = pkt_reg.pid;
    assign pid_byte = {~pid_bits, pid_bits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
            pkt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pkt_reg   <= pkt_next;
        end
    end

    always_comb begin
        at_last = 1'b0;
        case (state_reg)
            ST_SYNC, ST_PID, ST_ADDR, ST_ENDP: at_last = (cnt_reg == field_last(state_reg));
            ST_CRC:  at_last = (cnt_reg == CRC_LAST);
            ST_GAP:  at_last = (cnt_reg == GAP_LAST);
            default: at_last = 1'b0;
        endcase
    end

    // Abort wins over pause; pause freezes state and counter entirely.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pkt_next   = pkt_reg;
        if (abort) begin
            state_next = ST_IDLE;
            cnt_next   = 3'd0;
        end else if (!pause) begin
            if (state_reg == ST_IDLE) begin
                if (!fifo_empty) begin
                    pkt_next   = pkt_in;
                    state_next = ST_SYNC;
                    cnt_next   = 3'd0;
                end
            end else if (at_last) begin
                cnt_next = 3'd0;
                case (state_reg)
                    ST_SYNC: state_next = ST_PID;
                    ST_PID:  state_next = ST_ADDR;
                    ST_ADDR: state_next = ST_ENDP;
                    ST_ENDP: state_next = ST_CRC;
                    ST_CRC:  state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
                    default: state_next = ST_IDLE;
                endcase
            end else begin
                cnt_next = cnt_reg + 3'd1;
            end
        end
    end

    // Outputs follow the registered state, so a frozen state holds them too.
    always_comb begin
        fifo_re   = 1'b0;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        crc_start = 1'b0;
        crc_endr  = 1'b0;
        busy      = (state_reg != ST_IDLE);
        pkt_done  = 1'b0;
        case (state_reg)
            ST_IDLE: fifo_re = rst_n && !fifo_empty && !pause && !abort;
            ST_SYNC: begin
                bit_valid = 1'b1;
                bit_out   = SYNC_PATTERN[3'd7 - cnt_reg];
            end
            ST_PID: begin
                bit_valid = 1'b1;
                bit_out   = pid_byte[cnt_reg];
            end
            ST_ADDR: begin
                bit_valid = 1'b1;
                bit_out   = pkt_reg.addr[cnt_reg];
                crc_start = (cnt_reg == 3'd0);
            end
            ST_ENDP: begin
                bit_valid = 1'b1;
                bit_out   = pkt_reg.endp[cnt_reg[1:0]];
                crc_endr  = (cnt_reg == 3'(ENDP_LEN - 1));
            end
            ST_CRC:  pkt_done = at_last && !pause && !abort;
            default: ;
        endcase
    end

endmodule
